// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the 9-bit PC, issues one-shot word reads, and
// freezes across unresolved branches. Optional FETCH_PERF_EN adds fetch/branch-stall counters.
module fetch_sequencer #(
  parameter logic [8:0] RESET_PC    = 9'd0,
  parameter logic [5:0] HALT_OPCODE = 6'd63,
  parameter logic [5:0] BR_OP_LO    = 6'd15,
  parameter logic [5:0] BR_OP_HI    = 6'd20
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [8:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        resolve_valid,
  input  logic [8:0]  new_PC,
  output logic [31:0] inst_reg,
  output logic [8:0]  PC,
  output logic        inst_valid,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] br_stall_cycles
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_OUT     = 3'd3;
  localparam logic [2:0] S_BR_WAIT = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  logic [2:0] state;
  logic [2:0] state_next;
  logic [8:0] fetch_pc;
  logic [5:0] opcode;
  logic       is_branch;
  logic       is_halt;

  assign opcode    = inst_reg[31:26];
  assign is_branch = (opcode >= BR_OP_LO) && (opcode <= BR_OP_HI);
  assign is_halt   = (opcode == HALT_OPCODE);

  // Request and halt are pure state decodes, so reset clears them combinationally.
  assign imem_req  = (state == S_REQ);
  assign imem_addr = imem_req ? fetch_pc : 9'd0;
  assign halted    = (state == S_HALT);

  // NOTE: every combinational output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    state_next = S_REQ;
      S_REQ:     state_next = S_WAIT;
      S_WAIT:    if (imem_valid) state_next = S_OUT;
      S_OUT: begin
        if (!stall) begin
          if (is_branch)    state_next = S_BR_WAIT;
          else if (is_halt) state_next = S_HALT;
          else              state_next = S_REQ;
        end
      end
      S_BR_WAIT: if (resolve_valid) state_next = S_REQ;
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC;
      inst_reg   <= 32'd0;
      PC         <= 9'd0;
      inst_valid <= 1'b0;
    end else begin
      state <= state_next;
      unique case (state)
        S_WAIT: begin
          if (imem_valid) begin
            inst_reg   <= imem_rdata;
            PC         <= fetch_pc + 9'd1;
            fetch_pc   <= fetch_pc + 9'd1;
            inst_valid <= 1'b1;
          end
        end
        S_OUT:     if (!stall) inst_valid <= 1'b0;
        S_BR_WAIT: if (resolve_valid) fetch_pc <= new_PC;
        default:   ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count     <= 16'd0;
      br_stall_cycles <= 16'd0;
    end else begin
      if (imem_req && (fetch_count != 16'hFFFF))
        fetch_count <= fetch_count + 16'd1;
      if ((state == S_BR_WAIT) && (br_stall_cycles != 16'hFFFF))
        br_stall_cycles <= br_stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed program from the test plan, then
// randomized memory latency, stalls, branch resolution and resets against a transaction-level model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_valid = 1'b0;
  logic        stall = 1'b0;
  logic        resolve_valid = 1'b0;
  logic [8:0]  new_PC = 9'd0;
  logic [31:0] inst_reg;
  logic [8:0]  PC;
  logic        inst_valid;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] br_stall_cycles;
`endif

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .stall(stall), .resolve_valid(resolve_valid), .new_PC(new_PC),
    .inst_reg(inst_reg), .PC(PC), .inst_valid(inst_valid), .halted(halted)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .br_stall_cycles(br_stall_cycles)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  // Model: program memory plus what the next cycle must show.
  logic [31:0] mem [512];
  bit          req_due, outstanding, present_due, cur_valid, held, br_pending, halt_exp;
  bit          directed, rand_en;
  int          resp_cnt, lat, br_wait_cnt, res_delay, force_stall;
  int          req_total, br_total;
  logic [8:0]  exp_next_pc, resp_addr, cur_addr, br_pc;
  logic [31:0] cur_inst;
  int          req_log[$], req_cyc[$], pc_log[$], pc_cyc[$];
  logic [8:0]  br_targets[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic step();
    bit         exp_valid, req_now, pres_now;
    logic [5:0] op;
    logic [8:0] tgt, exp_pc;
    @(negedge clk);
    cycle++;
    check("halted", halted, halt_exp);
    check("imem_req", imem_req, req_due);
    if (req_due) check("imem_addr", imem_addr, exp_next_pc);
    if (imem_req) begin req_log.push_back(int'(imem_addr)); req_cyc.push_back(cycle); end
`ifdef FETCH_PERF_EN
    check("fetch_count", fetch_count, (req_total > 65535) ? 65535 : req_total);
    check("br_stall_cycles", br_stall_cycles, (br_total > 65535) ? 65535 : br_total);
`endif
    exp_valid = present_due || (cur_valid && held);
    check("inst_valid", inst_valid, exp_valid);
    if (present_due) begin
      cur_inst = mem[resp_addr];
      cur_addr = resp_addr;
      if (inst_valid) begin pc_log.push_back(int'(PC)); pc_cyc.push_back(cycle); end
    end
    if (exp_valid) begin
      exp_pc = cur_addr + 9'd1;
      check("inst_reg", inst_reg, cur_inst);
      check("PC", PC, exp_pc);
    end
    cur_valid = exp_valid;
    if (br_pending) br_total++;

    req_now  = req_due;
    pres_now = present_due;
    req_due = 0; present_due = 0; held = 0;

    // Memory response after lat cycles; junk valids elsewhere must be ignored.
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (outstanding) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        imem_valid = 1'b1; imem_rdata = mem[resp_addr]; present_due = 1; outstanding = 0;
      end
    end else if (rand_en && $urandom_range(0, 7) == 0) imem_valid = 1'b1;
    if (req_now) begin
      if (rand_en) lat = $urandom_range(1, 4);
      outstanding = 1; resp_cnt = lat; resp_addr = exp_next_pc; req_total++;
    end

    // Branch resolution; resolve pulses outside a pending branch must be ignored.
    resolve_valid = 1'b0;
    new_PC = 9'($urandom);
    if (br_pending) begin
      br_wait_cnt++;
      if (br_wait_cnt > res_delay) begin
        if (br_targets.size() > 0) tgt = br_targets.pop_front();
        else if ($urandom_range(0, 1) == 1) tgt = br_pc;
        else tgt = 9'($urandom);
        resolve_valid = 1'b1; new_PC = tgt;
        br_pending = 0; req_due = 1; exp_next_pc = tgt;
      end
    end else if (rand_en && $urandom_range(0, 5) == 0) resolve_valid = 1'b1;

    // Consumer side: stall only matters while an instruction is presented.
    stall = rand_en ? ($urandom_range(0, 2) == 0) : 1'b0;
    if (exp_valid) begin
      if (pres_now && directed && cur_inst == 32'h0400_0005) force_stall = 4;
      if (force_stall > 0) begin stall = 1'b1; force_stall--; end
      if (stall) held = 1;
      else begin
        op = cur_inst[31:26];
        if (op >= 6'd15 && op <= 6'd20) begin
          br_pending = 1; br_wait_cnt = 0; br_pc = cur_addr + 9'd1;
          if (rand_en) res_delay = $urandom_range(0, 4);
        end else if (op == 6'd63) halt_exp = 1;
        else begin req_due = 1; exp_next_pc = cur_addr + 9'd1; end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_inst_reg", inst_reg, 32'd0);
    check("rst_PC", PC, 9'd0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_imem_addr", imem_addr, 9'd0);
    check("rst_halted", halted, 1'b0);
`ifdef FETCH_PERF_EN
    check("rst_fetch_count", fetch_count, 16'd0);
    check("rst_br_stall_cycles", br_stall_cycles, 16'd0);
`endif
    req_due = 0; outstanding = 0; present_due = 0; cur_valid = 0; held = 0;
    br_pending = 0; halt_exp = 0; force_stall = 0; req_total = 0; br_total = 0;
    imem_valid = 1'b1;
    imem_rdata = 32'h0400_0007;
    repeat (2) @(negedge clk);
    check("rst_hold_inst_valid", inst_valid, 1'b0);
    rst_n = 1'b1;
    req_due = 1; exp_next_pc = 9'd0;
  endtask

  initial begin
    int         req_seq[17];
    int         r, halt_steps;
    logic [5:0] op;
    req_seq = '{0, 1, 2, 3, 4, 5, 40, 41, 510, 511, 0, 1, 2, 3, 4, 5, 100};

    for (int a = 0; a < 512; a++) mem[a] = 32'd0;
    for (int a = 0; a < 4; a++) mem[a] = 32'h0400_0000 | 32'(a);
    mem[4]   = 32'h0400_0005;
    mem[5]   = {6'd15, 26'd0};
    mem[40]  = 32'h0400_0028;
    mem[41]  = {6'd17, 26'd3};
    mem[510] = 32'h0400_01FE;
    mem[511] = {6'd16, 26'd0};
    mem[100] = {6'd63, 26'd0};
    br_targets = '{9'd40, 9'd510, 9'd0, 9'd100};
    directed = 1; rand_en = 0; lat = 1; res_delay = 3;

    do_reset();
    for (int k = 0; k < 300 && req_log.size() < 7; k++) step();
    check("reach_branch_target", req_log.size() >= 7, 1'b1);
    if (req_log.size() >= 7) check("taken_target_addr", req_log[6], 40);
`ifdef FETCH_PERF_EN
    check("perf_fetch_after_branch", fetch_count, 16'd6);
    check("perf_br_stall_after_branch", br_stall_cycles, 16'd4);
`endif
    for (int k = 0; k < 600 && !halt_exp; k++) step();
    check("reach_halt", halt_exp, 1'b1);
    repeat (20) step();

    check("req_seq_len", req_log.size(), 17);
    for (int i = 0; i < 17 && i < req_log.size(); i++)
      check($sformatf("req_addr_%0d", i), req_log[i], req_seq[i]);
    if (pc_log.size() >= 10) begin
      check("pc_first", pc_log[0], 1);
      check("pc_fourth", pc_log[3], 4);
      check("pc_after_taken", pc_log[6], 41);
      check("pc_wrap_511", pc_log[9], 0);
    end else check("pc_log_len", pc_log.size(), 10);
    if (req_cyc.size() >= 4 && pc_cyc.size() >= 1) begin
      check("throughput_3cyc", req_cyc[1] - req_cyc[0], 3);
      check("latency_mem1", pc_cyc[0] - req_cyc[0], 2);
      check("stall_gap", req_cyc[5] - req_cyc[4], 7);
    end

    // Reset in the middle of a 3-cycle memory wait; the late response must be ignored.
    do_reset();
    lat = 3;
    r = req_log.size();
    for (int k = 0; k < 20 && req_log.size() == r; k++) step();
    step();
    do_reset();
    repeat (12) step();

    // Randomized phase.
    for (int a = 0; a < 512; a++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      op = 6'(15 + $urandom_range(0, 5));
      else if (r < 13) op = 6'd63;
      else begin
        op = 6'($urandom_range(0, 56));
        if (op >= 6'd15) op = op + 6'd6;
      end
      mem[a] = {op, 26'($urandom)};
    end
    br_targets.delete();
    directed = 0; rand_en = 1;
    do_reset();
    halt_steps = 0;
    for (int k = 0; k < 4000; k++) begin
      step();
      if (halt_exp) halt_steps++;
      if (halt_steps > 5 || $urandom_range(0, 399) == 0) begin
        halt_steps = 0;
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cycle);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
